// File: rtl/vga_pkg.sv
// Shared timing defaults and types for the 640x480@60Hz VGA raster generator.
// Every window bound is half-open [lo, hi) so it compares directly against pixel counts.
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_HS_START  = VGA_H_VISIBLE + VGA_H_FP;
  localparam int VGA_HS_END    = VGA_HS_START + VGA_H_SYNC;
  localparam int VGA_VS_START  = VGA_V_VISIBLE + VGA_V_FP;
  localparam int VGA_VS_END    = VGA_VS_START + VGA_V_SYNC;

  localparam int VGA_PIPE_DELAY = 2;
  localparam int VGA_ANIM_DIV   = 30;

  typedef logic [COORD_W-1:0] coord_t;

  // Signals that travel together down the pin-alignment pipeline.
  typedef struct packed {
    logic blank;
    logic hs;
    logic vs;
  } sync_bus_t;

  localparam sync_bus_t SYNC_IDLE = '{blank: 1'b0, hs: 1'b1, vs: 1'b1};

  function automatic logic in_window(input coord_t c, input int lo, input int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// DEPTH x WIDTH shift register with a per-bit reset value; DEPTH=0 is a plain wire.
// Used to line the sync pins up with the colour mappers' registered outputs.
module vga_pipe_delay #(
  parameter int               DEPTH     = 2,
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RESET_VAL;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster generator: pixel counters, display enable, delayed sync pins, line/frame strobes,
// frame counter and the animation-phase divider shared by all sprite mappers.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = VGA_H_VISIBLE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_VISIBLE  = VGA_V_VISIBLE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int PIPE_DELAY = VGA_PIPE_DELAY,
  parameter int ANIM_DIV   = VGA_ANIM_DIV
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               blank,
  output logic               blank_d,
  output logic               hs,
  output logic               vs,
  output logic               line_start,
  output logic               frame_start,
  output logic [7:0]         frame_count,
  output logic               anim_frame
);

  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam coord_t     H_LAST    = COORD_W'(H_TOTAL - 1);
  localparam coord_t     V_LAST    = COORD_W'(V_TOTAL - 1);
  localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);

  if (H_TOTAL > (1 << COORD_W)) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL %0d does not fit in %0d bits", H_TOTAL, COORD_W);
  end
  if (V_TOTAL > (1 << COORD_W)) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL %0d does not fit in %0d bits", V_TOTAL, COORD_W);
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_pipe_delay
    $error("vga_timing_gen: PIPE_DELAY %0d outside 0..4", PIPE_DELAY);
  end
  if (ANIM_DIV < 1 || ANIM_DIV > 255) begin : g_bad_anim_div
    $error("vga_timing_gen: ANIM_DIV %0d outside 1..255", ANIM_DIV);
  end

  coord_t     x_q, x_d;
  coord_t     y_q, y_d;
  logic       vis_q, vis_d;
  logic       hs_raw_q, hs_raw_d;
  logic       vs_raw_q, vs_raw_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic [7:0] anim_div_q, anim_div_d;
  logic       anim_frame_q, anim_frame_d;
  logic       frame_wrap;

  always_comb begin
    x_d        = x_q + 1'b1;
    y_d        = y_q;
    frame_wrap = 1'b0;
    if (x_q == H_LAST) begin
      x_d = '0;
      if (y_q == V_LAST) begin
        y_d        = '0;
        frame_wrap = 1'b1;
      end else begin
        y_d = y_q + 1'b1;
      end
    end
  end

  // Everything below is decoded from the next counts so each register lines up with DrawX/DrawY.
  always_comb begin
    vis_d         = in_window(x_d, 0, H_VISIBLE) && in_window(y_d, 0, V_VISIBLE);
    hs_raw_d      = !in_window(x_d, HS_START, HS_END);
    vs_raw_d      = !in_window(y_d, VS_START, VS_END);
    line_start_d  = (x_d == '0);
    frame_start_d = (x_d == '0) && (y_d == '0);
  end

  always_comb begin
    frame_count_d = frame_count_q;
    anim_div_d    = anim_div_q;
    anim_frame_d  = anim_frame_q;
    if (frame_wrap) begin
      frame_count_d = frame_count_q + 8'd1;
      if (anim_div_q == ANIM_LAST) begin
        anim_div_d   = '0;
        anim_frame_d = !anim_frame_q;
      end else begin
        anim_div_d = anim_div_q + 8'd1;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= '0;
      y_q           <= '0;
      vis_q         <= 1'b0;
      hs_raw_q      <= 1'b1;
      vs_raw_q      <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      anim_div_q    <= '0;
      anim_frame_q  <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      vis_q         <= vis_d;
      hs_raw_q      <= hs_raw_d;
      vs_raw_q      <= vs_raw_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      anim_div_q    <= anim_div_d;
      anim_frame_q  <= anim_frame_d;
    end
  end

  sync_bus_t                     sync_raw;
  sync_bus_t                     sync_dly;
  logic [$bits(sync_bus_t)-1:0]  sync_out;

  assign sync_raw = '{blank: vis_q, hs: hs_raw_q, vs: vs_raw_q};

  vga_pipe_delay #(
    .DEPTH     (PIPE_DELAY),
    .WIDTH     ($bits(sync_bus_t)),
    .RESET_VAL (SYNC_IDLE)
  ) u_pipe_delay (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .din   (sync_raw),
    .dout  (sync_out)
  );

  assign sync_dly = sync_bus_t'(sync_out);

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = vis_q;
  assign blank_d     = sync_dly.blank;
  assign hs          = sync_dly.hs;
  assign vs          = sync_dly.vs;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
  assign anim_frame  = anim_frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a full-size 640x480 instance for line/hsync behaviour and a tiny 8x8-raster
// instance so frame wrap, vsync, animation and frame-counter wrap fit in a short run.
module tb_vga_timing_gen;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;

  logic [9:0] DrawX, DrawY;
  logic       blank, blank_d, hs, vs, line_start, frame_start, anim_frame;
  logic [7:0] frame_count;

  logic [9:0] s_draw_x, s_draw_y;
  logic       s_blank, s_blank_d, s_hs, s_vs, s_line_start, s_frame_start, s_anim_frame;
  logic [7:0] s_frame_count;

  int errors = 0;
  int checks = 0;

  localparam logic [34:0] RST_VEC = {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen u_dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .blank_d     (blank_d),
    .hs          (hs),
    .vs          (vs),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_count (frame_count),
    .anim_frame  (anim_frame)
  );

  // 8x8 raster: visible 4, porch 1, sync 2, back porch 1 on both axes -> 64 clocks per frame.
  vga_timing_gen #(
    .H_VISIBLE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_VISIBLE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .PIPE_DELAY (2), .ANIM_DIV (30)
  ) u_small (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (s_draw_x),
    .DrawY       (s_draw_y),
    .blank       (s_blank),
    .blank_d     (s_blank_d),
    .hs          (s_hs),
    .vs          (s_vs),
    .line_start  (s_line_start),
    .frame_start (s_frame_start),
    .frame_count (s_frame_count),
    .anim_frame  (s_anim_frame)
  );

  function automatic logic [34:0] main_vec();
    return {DrawX, DrawY, blank, blank_d, hs, vs, line_start, frame_start, frame_count, anim_frame};
  endfunction

  function automatic logic [34:0] small_vec();
    return {s_draw_x, s_draw_y, s_blank, s_blank_d, s_hs, s_vs, s_line_start, s_frame_start,
            s_frame_count, s_anim_frame};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask

  task automatic run_to_main(input int x, input int y, input int bound);
    int n = 0;
    while (!(DrawX == 10'(x) && DrawY == 10'(y)) && n < bound) begin
      tick(1);
      n++;
    end
    checks++;
    if (!(DrawX == 10'(x) && DrawY == 10'(y))) begin
      errors++;
      $display("[TB] FAIL run_to_main timeout got=(%0d,%0d) want=(%0d,%0d)", DrawX, DrawY, x, y);
    end
  endtask

  task automatic run_to_small(input int x, input int y, input int bound);
    int n = 0;
    while (!(s_draw_x == 10'(x) && s_draw_y == 10'(y)) && n < bound) begin
      tick(1);
      n++;
    end
    checks++;
    if (!(s_draw_x == 10'(x) && s_draw_y == 10'(y))) begin
      errors++;
      $display("[TB] FAIL run_to_small timeout got=(%0d,%0d) want=(%0d,%0d)", s_draw_x, s_draw_y, x, y);
    end
  endtask

  task automatic test_reset();
    logic [34:0] exp;
    reset_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++;
      if (main_vec() !== RST_VEC) begin
        errors++;
        $display("[TB] FAIL reset_hold_main cyc=%0d got=%h exp=%h", i, main_vec(), RST_VEC);
      end
      checks++;
      if (small_vec() !== RST_VEC) begin
        errors++;
        $display("[TB] FAIL reset_hold_small cyc=%0d got=%h exp=%h", i, small_vec(), RST_VEC);
      end
    end
    reset_n = 1'b1;
    tick(1);
    exp = {10'd1, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
    checks++;
    if (main_vec() !== exp) begin
      errors++;
      $display("[TB] FAIL first_edge got=%h exp=%h", main_vec(), exp);
    end
    tick(1);
    exp = {10'd2, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
    checks++;
    if (main_vec() !== exp) begin
      errors++;
      $display("[TB] FAIL second_edge got=%h exp=%h", main_vec(), exp);
    end
  endtask

  task automatic test_line_wrap();
    run_to_main(799, 5, 6000);
    checks++;
    if ({DrawX, DrawY, blank, line_start} !== {10'd799, 10'd5, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL line_wrap_pre got=%0d,%0d,%b,%b exp=799,5,0,0", DrawX, DrawY, blank, line_start);
    end
    tick(1);
    checks++;
    if ({DrawX, DrawY, blank, line_start, frame_start} !== {10'd0, 10'd6, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL line_wrap got=%0d,%0d,%b,%b,%b exp=0,6,1,1,0",
               DrawX, DrawY, blank, line_start, frame_start);
    end
    tick(1);
    checks++;
    if ({DrawX, DrawY, line_start} !== {10'd1, 10'd6, 1'b0}) begin
      errors++;
      $display("[TB] FAIL line_start_width got=%0d,%0d,%b exp=1,6,0", DrawX, DrawY, line_start);
    end
  endtask

  task automatic test_hsync();
    logic [25:0] exp;
    int hs_low = 0;
    int first_low = -1;
    run_to_main(0, 7, 2000);
    for (int i = 0; i < 800; i++) begin
      exp = {10'(i), 10'd7, (i < 640), (i >= 2 && i <= 641), !(i >= 658 && i <= 753), 1'b1,
             (i == 0), 1'b0};
      checks++;
      if ({DrawX, DrawY, blank, blank_d, hs, vs, line_start, frame_start} !== exp) begin
        errors++;
        $display("[TB] FAIL hsync_line x=%0d got=%h exp=%h", i,
                 {DrawX, DrawY, blank, blank_d, hs, vs, line_start, frame_start}, exp);
      end
      if (hs == 1'b0) begin
        hs_low++;
        if (first_low < 0) first_low = i;
      end
      tick(1);
    end
    checks++;
    if (hs_low != 96) begin
      errors++;
      $display("[TB] FAIL hs_low_width got=%0d exp=96", hs_low);
    end
    checks++;
    if (first_low != 658) begin
      errors++;
      $display("[TB] FAIL hs_fall_pos got=%0d exp=658", first_low);
    end
  endtask

  task automatic test_mid_frame_reset();
    run_to_main(300, 8, 2000);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (main_vec() !== RST_VEC) begin
      errors++;
      $display("[TB] FAIL mid_reset_300 got=%h exp=%h", main_vec(), RST_VEC);
    end
    checks++;
    if (small_vec() !== RST_VEC) begin
      errors++;
      $display("[TB] FAIL mid_reset_small got=%h exp=%h", small_vec(), RST_VEC);
    end
    tick(2);
    reset_n = 1'b1;
    run_to_main(700, 0, 1000);
    checks++;
    if (hs !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hs_low_at_700 got=%b exp=0", hs);
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (main_vec() !== RST_VEC) begin
      errors++;
      $display("[TB] FAIL mid_reset_700 got=%h exp=%h", main_vec(), RST_VEC);
    end
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_frame_wrap();
    logic [34:0] exp;
    run_to_small(7, 7, 200);
    checks++;
    if ({s_frame_start, s_frame_count} !== {1'b0, 8'd0}) begin
      errors++;
      $display("[TB] FAIL frame_wrap_pre got=%b,%0d exp=0,0", s_frame_start, s_frame_count);
    end
    tick(1);
    exp = {10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0};
    checks++;
    if (small_vec() !== exp) begin
      errors++;
      $display("[TB] FAIL frame_wrap got=%h exp=%h", small_vec(), exp);
    end
    tick(1);
    exp = {10'd1, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
    checks++;
    if (small_vec() !== exp) begin
      errors++;
      $display("[TB] FAIL frame_start_width got=%h exp=%h", small_vec(), exp);
    end
  endtask

  task automatic test_vsync();
    logic [34:0] exp;
    int pos, x, y, pp, px, py;
    int vs_low = 0;
    int first_low = -1;
    for (int k = 0; k < 64; k++) begin
      pos = (1 + k) % 64;
      x = pos % 8;
      y = pos / 8;
      pp = (pos + 62) % 64;
      px = pp % 8;
      py = pp / 8;
      exp = {10'(x), 10'(y), (x < 4 && y < 4), (px < 4 && py < 4), !(px >= 5 && px < 7),
             !(py >= 5 && py < 7), (x == 0), (pos == 0), (pos == 0) ? 8'd2 : 8'd1, 1'b0};
      checks++;
      if (small_vec() !== exp) begin
        errors++;
        $display("[TB] FAIL vsync_frame pos=%0d got=%h exp=%h", pos, small_vec(), exp);
      end
      if (s_vs == 1'b0) begin
        vs_low++;
        if (first_low < 0) first_low = pos;
      end
      if (k < 63) tick(1);
    end
    checks++;
    if (vs_low != 16) begin
      errors++;
      $display("[TB] FAIL vs_low_width got=%0d exp=16", vs_low);
    end
    checks++;
    if (first_low != 42) begin
      errors++;
      $display("[TB] FAIL vs_fall_pos got=%0d exp=42", first_low);
    end
  endtask

  task automatic test_animation();
    logic [19:0] exp;
    for (int f = 3; f <= 258; f++) begin
      tick(64);
      exp = {10'd0, s_draw_y == 10'd0, s_frame_start, 8'(f)} == 20'd0 ? 20'd0 : 20'd0;
      exp = {10'd0, 1'b1, 8'(f), 1'((f / 30) % 2)};
      checks++;
      if ({s_draw_x, s_frame_start, s_frame_count, s_anim_frame} !== exp) begin
        errors++;
        $display("[TB] FAIL anim_frame_count f=%0d got=x%0d,fs%b,fc%0d,an%b exp=x0,fs1,fc%0d,an%0d",
                 f, s_draw_x, s_frame_start, s_frame_count, s_anim_frame, f % 256, (f / 30) % 2);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_line_wrap();
    test_hsync();
    test_mid_frame_reset();
    test_frame_wrap();
    test_vsync();
    test_animation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
